// File: rtl/register_file.sv
// 31 x 64-bit architectural register file with hardwired-zero X31, two combinational
// read ports, one write port and a branch-and-link write path into X30.

module decoder_5to32 (
  input  logic        en_i,
  input  logic [4:0]  sel_i,
  output logic [31:0] onehot_o
);
  assign onehot_o = en_i ? (32'b1 << sel_i) : 32'b0;
endmodule

module mux_64w32to1 #(
  parameter int W = 64
) (
  input  logic [31:0][W-1:0] data_i,
  input  logic [4:0]         sel_i,
  output logic [W-1:0]       y_o
);
  assign y_o = data_i[sel_i];
endmodule

module mux2_64b #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

module register_file #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              blink_sig,
  input  logic [DATA_W-1:0] link_register
);

  localparam int LINK_IDX = NREGS - 2;

  logic [DATA_W-1:0]            regs_q [0:NREGS-2];
  logic [DATA_W-1:0]            regs_d [0:NREGS-2];
  logic [NREGS-1:0][DATA_W-1:0] rd_vec;
  logic [31:0]                  we_vec;
  logic [DATA_W-1:0]            link_wdata;
  logic                         unused_we31;

  decoder_5to32 u_dec (
    .en_i     (RegWrite),
    .sel_i    (WriteRegister),
    .onehot_o (we_vec)
  );

  // Writes aimed at X31 decode to bit 31, which has no storage behind it.
  assign unused_we31 = we_vec[31];

  mux2_64b #(.W(DATA_W)) u_link_mux (
    .a_i   (WriteData),
    .b_i   (link_register),
    .sel_i (blink_sig),
    .y_o   (link_wdata)
  );

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < LINK_IDX; i++) begin
      if (we_vec[i]) regs_d[i] = WriteData;
    end
    if (we_vec[LINK_IDX] || blink_sig) regs_d[LINK_IDX] = link_wdata;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS - 1; i++) begin
      if (!reset) regs_q[i] <= '0;
      else        regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rd_vec[NREGS-1] = '0;
    for (int i = 0; i < NREGS - 1; i++) rd_vec[i] = regs_q[i];
  end

  mux_64w32to1 #(.W(DATA_W)) u_rd1_mux (
    .data_i (rd_vec),
    .sel_i  (ReadRegister1),
    .y_o    (ReadData1)
  );

  mux_64w32to1 #(.W(DATA_W)) u_rd2_mux (
    .data_i (rd_vec),
    .sel_i  (ReadRegister2),
    .y_o    (ReadData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, X31, fill pattern, no-bypass, link path.

module tb_register_file;

  localparam logic [63:0] PAT = 64'h0000010204080001;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic        blink_sig;
  logic [63:0] link_register;

  int n_vec = 0;
  int n_err = 0;

  register_file dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .blink_sig     (blink_sig),
    .link_register (link_register)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One clock edge with the given write controls, outputs settled #1 after it.
  task automatic cyc(input logic rst_n, input logic we, input logic [4:0] idx,
                     input logic [63:0] data, input logic bl, input logic [63:0] lnk);
    @(negedge clk);
    reset = rst_n; RegWrite = we; WriteRegister = idx; WriteData = data;
    blink_sig = bl; link_register = lnk;
    @(posedge clk);
    #1;
    reset = 1'b1; RegWrite = 1'b0; blink_sig = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    ReadRegister1 = a; ReadRegister2 = b;
    #1;
  endtask

  function automatic logic [63:0] pat_of(input int i);
    return (i == 31) ? 64'h0 : PAT * 64'(i);
  endfunction

  initial begin
    reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0; blink_sig = 1'b0; link_register = '0;

    cyc(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0);
    rd(5'd0, 5'd15);  chk("rst_x0", ReadData1, 64'h0); chk("rst_x15", ReadData2, 64'h0);
    rd(5'd30, 5'd31); chk("rst_x30", ReadData1, 64'h0); chk("rst_x31", ReadData2, 64'h0);

    cyc(1'b1, 1'b1, 5'd31, 64'hA0, 1'b0, 64'h0);
    rd(5'd31, 5'd31); chk("x31_p1", ReadData1, 64'h0); chk("x31_p2", ReadData2, 64'h0);
    rd(5'd0, 5'd30);  chk("x31_x0", ReadData1, 64'h0); chk("x31_x30", ReadData2, 64'h0);

    for (int i = 0; i < 31; i++) cyc(1'b1, 1'b1, 5'(i), PAT * 64'(i), 1'b0, 64'h0);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      chk($sformatf("fill_p1_x%0d", i), ReadData1, pat_of(i));
      chk($sformatf("fill_p2_x%0d", 31 - i), ReadData2, pat_of(31 - i));
    end

    rd(5'd7, 5'd7);
    chk("same_p1", ReadData1, PAT * 64'd7); chk("same_p2", ReadData2, PAT * 64'd7);

    // Reads must show the old X5 while the write is pending, the new one after the edge.
    ReadRegister2 = 5'd5;
    @(negedge clk);
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'h77;
    #1;
    chk("nobyp_before", ReadData2, PAT * 64'd5);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    chk("nobyp_after", ReadData2, 64'h77);

    cyc(1'b1, 1'b0, 5'd3, 64'hFFFF, 1'b0, 64'h0);
    rd(5'd3, 5'd4); chk("we0_x3", ReadData1, PAT * 64'd3); chk("we0_x4", ReadData2, PAT * 64'd4);

    cyc(1'b1, 1'b1, 5'd30, 64'h55, 1'b1, 64'h1234);
    rd(5'd30, 5'd29); chk("lnk_conf_x30", ReadData1, 64'h1234); chk("lnk_conf_x29", ReadData2, PAT * 64'd29);

    cyc(1'b1, 1'b1, 5'd2, 64'h9, 1'b1, 64'hBEEF);
    rd(5'd30, 5'd2); chk("lnk_conc_x30", ReadData1, 64'hBEEF); chk("lnk_conc_x2", ReadData2, 64'h9);

    cyc(1'b1, 1'b0, 5'd1, 64'h3, 1'b1, 64'hCAFE);
    rd(5'd30, 5'd1); chk("lnk_only_x30", ReadData1, 64'hCAFE); chk("lnk_only_x1", ReadData2, PAT * 64'd1);

    cyc(1'b0, 1'b1, 5'd7, 64'hDEAD, 1'b1, 64'hF00D);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      chk($sformatf("rst2_p1_x%0d", i), ReadData1, 64'h0);
      chk($sformatf("rst2_p2_x%0d", 31 - i), ReadData2, 64'h0);
    end

    cyc(1'b1, 1'b1, 5'd7, 64'h42, 1'b0, 64'h0);
    rd(5'd7, 5'd8); chk("post_rst_x7", ReadData1, 64'h42); chk("post_rst_x8", ReadData2, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
